// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-low 7-segment glyph encodings, bit order {g,f,e,d,c,b,a}
package seg7_pkg;
    localparam logic [6:0] GLYPH_0    = 7'b1000000;
    localparam logic [6:0] GLYPH_1    = 7'b1111001;
    localparam logic [6:0] GLYPH_2    = 7'b0100100;
    localparam logic [6:0] GLYPH_3    = 7'b0110000;
    localparam logic [6:0] GLYPH_4    = 7'b0011001;
    localparam logic [6:0] GLYPH_5    = 7'b0010010;
    localparam logic [6:0] GLYPH_6    = 7'b0000010;
    localparam logic [6:0] GLYPH_7    = 7'b1111000;
    localparam logic [6:0] GLYPH_8    = 7'b0000000;
    localparam logic [6:0] GLYPH_9    = 7'b0010000;
    localparam logic [6:0] GLYPH_A    = 7'b0001000;
    localparam logic [6:0] GLYPH_B    = 7'b0000011;
    localparam logic [6:0] GLYPH_C    = 7'b1000110;
    localparam logic [6:0] GLYPH_D    = 7'b0100001;
    localparam logic [6:0] GLYPH_E    = 7'b0000110;
    localparam logic [6:0] GLYPH_F    = 7'b0001110;
    localparam logic [6:0] GLYPH_DASH = 7'b0111111;
    localparam logic [6:0] GLYPH_DARK = 7'b1111111;
endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: nibble to active-low {g..a} segments; without hex_mode 10 is a dash and 11..15 are dark
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    input  logic       hex_mode,
    output logic [6:0] segments
);
    always_comb begin
        segments = GLYPH_DARK;
        case (value)
            4'h0: segments = GLYPH_0;
            4'h1: segments = GLYPH_1;
            4'h2: segments = GLYPH_2;
            4'h3: segments = GLYPH_3;
            4'h4: segments = GLYPH_4;
            4'h5: segments = GLYPH_5;
            4'h6: segments = GLYPH_6;
            4'h7: segments = GLYPH_7;
            4'h8: segments = GLYPH_8;
            4'h9: segments = GLYPH_9;
            4'hA: segments = hex_mode ? GLYPH_A : GLYPH_DASH;
            4'hB: segments = hex_mode ? GLYPH_B : GLYPH_DARK;
            4'hC: segments = hex_mode ? GLYPH_C : GLYPH_DARK;
            4'hD: segments = hex_mode ? GLYPH_D : GLYPH_DARK;
            4'hE: segments = hex_mode ? GLYPH_E : GLYPH_DARK;
            4'hF: segments = hex_mode ? GLYPH_F : GLYPH_DARK;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit 7-segment scanner with frame snapshot, blink and leading-zero blanking
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLINK_LOG2     = 25,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lz_blank,
    input  logic                  hex_mode,
    output logic [N_DIGITS-1:0]   DIGIT,
    output logic [6:0]            DISPLAY,
    output logic                  DP,
    output logic                  frame_done
);
    localparam int PW = $clog2(REFRESH_CYCLES);
    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);
    localparam logic [PW-1:0] TERM = PW'(REFRESH_CYCLES - 1);
    localparam logic INV = !ACTIVE_LOW;

    logic [PW-1:0]         cnt_q, cnt_d;
    logic [BLINK_LOG2-1:0] blk_q, blk_d;
    logic                  phase_q, phase_d;
    logic [CW-1:0]         cur_q, cur_d;
    logic                  started_q, started_d;
    logic [4*N_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [N_DIGITS-1:0]   snap_blank_q, snap_blank_d;
    logic [N_DIGITS-1:0]   snap_blink_q, snap_blink_d;
    logic                  snap_lz_q, snap_lz_d;
    logic                  snap_hex_q, snap_hex_d;
    logic [N_DIGITS-1:0]   digit_q, digit_d;
    logic [6:0]            display_q, display_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;
    logic                  tick, wrap, upper_zero, lz_hit, dark;
    logic [3:0]            nib;
    logic [6:0]            glyph;

    // The *_d snapshot values equal the live inputs on the wrap edge, so they serve every slot of the frame.
    always_comb begin
        tick          = enable && (cnt_q == TERM);
        wrap          = tick && (cur_q == LAST);
        cnt_d         = !enable ? cnt_q : (tick ? '0 : cnt_q + 1'b1);
        blk_d         = enable ? blk_q + 1'b1 : blk_q;
        phase_d       = phase_q ^ (enable && (&blk_q));
        cur_d         = !tick ? cur_q : (wrap ? '0 : cur_q + 1'b1);
        started_d     = started_q | tick;
        snap_digits_d = wrap ? digits : snap_digits_q;
        snap_dp_d     = wrap ? dp_in : snap_dp_q;
        snap_blank_d  = wrap ? blank_mask : snap_blank_q;
        snap_blink_d  = wrap ? blink_mask : snap_blink_q;
        snap_lz_d     = wrap ? lz_blank : snap_lz_q;
        snap_hex_d    = wrap ? hex_mode : snap_hex_q;
        frame_done_d  = wrap && started_q;
    end

    always_comb begin
        upper_zero = 1'b1;
        lz_hit     = 1'b0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (snap_digits_d[4*i +: 4] == 4'd0);
            if (cur_d == CW'(i)) lz_hit = snap_lz_d && upper_zero;
        end
    end

    assign nib  = snap_digits_d[{cur_d, 2'b00} +: 4];
    assign dark = snap_blank_d[cur_d] | (snap_blink_d[cur_d] & phase_q) | lz_hit;

    seg7_glyph_decode u_glyph (
        .value    (nib),
        .hex_mode (snap_hex_d),
        .segments (glyph)
    );

    always_comb begin
        digit_d   = !enable ? {N_DIGITS{ACTIVE_LOW}} : !tick ? digit_q :
                    ((dark ? '1 : ~(N_DIGITS'(1) << cur_d)) ^ {N_DIGITS{INV}});
        display_d = !enable ? {7{ACTIVE_LOW}} : !tick ? display_q :
                    ((dark ? GLYPH_DARK : glyph) ^ {7{INV}});
        dp_d      = !enable ? ACTIVE_LOW : !tick ? dp_q : (!(snap_dp_d[cur_d] && !dark) ^ INV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            blk_q         <= '0;
            phase_q       <= 1'b0;
            cur_q         <= LAST;
            started_q     <= 1'b0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
            snap_blink_q  <= '0;
            snap_lz_q     <= 1'b0;
            snap_hex_q    <= 1'b0;
            digit_q       <= {N_DIGITS{ACTIVE_LOW}};
            display_q     <= {7{ACTIVE_LOW}};
            dp_q          <= ACTIVE_LOW;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            blk_q         <= blk_d;
            phase_q       <= phase_d;
            cur_q         <= cur_d;
            started_q     <= started_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_blank_q  <= snap_blank_d;
            snap_blink_q  <= snap_blink_d;
            snap_lz_q     <= snap_lz_d;
            snap_hex_q    <= snap_hex_d;
            digit_q       <= digit_d;
            display_q     <= display_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign DIGIT      = digit_q;
    assign DISPLAY    = display_q;
    assign DP         = dp_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for the 4-digit scanner with a 4-cycle slot and 32-cycle blink halves
module tb_seg7_scan_driver;
    localparam int REF = 4;
    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, GA = 7'b0001000, GB = 7'b0000011, GC = 7'b1000110;
    localparam logic [6:0] GD = 7'b0100001, GDASH = 7'b0111111, GDARK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic        lz_blank = 1'b0;
    logic        hex_mode = 1'b0;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
    logic        DP;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int ecyc = 0;
    int ph;

    typedef struct {
        string      tag;
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       sc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS       (4),
        .REFRESH_CYCLES (REF),
        .BLINK_LOG2     (5),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .hex_mode   (hex_mode),
        .DIGIT      (DIGIT),
        .DISPLAY    (DISPLAY),
        .DP         (DP),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] dig, input logic [6:0] seg,
                        input logic dp, input logic fd, input logic sc = 1'b1);
        exp_t e;
        e.tag = tag;
        e.dig = dig;
        e.seg = seg;
        e.dp  = dp;
        e.fd  = fd;
        e.sc  = sc;
        sb.push_back(e);
    endtask

    // dpn is the expected DP pin level per digit (0 = lit)
    task automatic push_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpn, input logic fd);
        push({tag, "0"}, 4'b1110, s0, dpn[0], fd);
        push({tag, "1"}, 4'b1101, s1, dpn[1], 1'b0);
        push({tag, "2"}, 4'b1011, s2, dpn[2], 1'b0);
        push({tag, "3"}, 4'b0111, s3, dpn[3], 1'b0);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".digit"}, 32'(DIGIT), 32'(e.dig));
        if (e.sc) chk({e.tag, ".display"}, 32'(DISPLAY), 32'(e.seg));
        chk({e.tag, ".dp"}, 32'(DP), 32'(e.dp));
        chk({e.tag, ".frame_done"}, 32'(frame_done), 32'(e.fd));
    endtask

    task automatic run_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            if (enable) ecyc++;
        end
        #1;
        pop_check();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 push("rst_init", 4'b1111, GDARK, 1'b1, 1'b0);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        push_frame("pre", G4, G3, G2, G1, 4'hF, 1'b0);
        repeat (3) run_edges(REF);
        sb.delete();
        #2 rst_n = 1'b0;
        #1 push("rst_mid", 4'b1111, GDARK, 1'b1, 1'b0);
        pop_check();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ecyc = 0;
        push_frame("A", G4, G3, G2, G1, 4'hF, 1'b0);
        repeat (4) run_edges(REF);
        push_frame("B", G4, G3, G2, G1, 4'hF, 1'b1);
        push_frame("C", G8, G7, G6, G5, 4'b1011, 1'b1);
        repeat (2) run_edges(REF);
        digits = 16'h5678;
        dp_in  = 4'b0100;
        repeat (6) run_edges(REF);
        digits   = 16'hABCD;
        hex_mode = 1'b1;
        dp_in    = 4'h0;
        push_frame("D", GD, GC, GB, GA, 4'hF, 1'b1);
        repeat (4) run_edges(REF);
        hex_mode = 1'b0;
        push_frame("E", GDARK, GDARK, GDARK, GDASH, 4'hF, 1'b1);
        repeat (4) run_edges(REF);
        lz_blank = 1'b1;
        digits   = 16'h0050;
        push("F0", 4'b1110, G0, 1'b1, 1'b1);
        push("F1", 4'b1101, G5, 1'b1, 1'b0);
        push("F2", 4'b1111, GDARK, 1'b1, 1'b0, 1'b0);
        push("F3", 4'b1111, GDARK, 1'b1, 1'b0, 1'b0);
        repeat (4) run_edges(REF);
        digits = 16'h0000;
        dp_in  = 4'hF;
        push("G0", 4'b1110, G0, 1'b0, 1'b1);
        push("G1", 4'b1111, GDARK, 1'b1, 1'b0, 1'b0);
        push("G2", 4'b1111, GDARK, 1'b1, 1'b0, 1'b0);
        push("G3", 4'b1111, GDARK, 1'b1, 1'b0, 1'b0);
        repeat (4) run_edges(REF);
        lz_blank = 1'b0;
        dp_in    = 4'h0;
        digits   = 16'h1234;
        push("H0", 4'b1110, G4, 1'b1, 1'b1);
        push("H1", 4'b1101, G3, 1'b1, 1'b0);
        repeat (2) run_edges(REF);
        enable = 1'b0;
        push("off_first", 4'b1111, GDARK, 1'b1, 1'b0);
        run_edges(1);
        push("off_hold", 4'b1111, GDARK, 1'b1, 1'b0);
        run_edges(9);
        enable = 1'b1;
        push("resume_dark", 4'b1111, GDARK, 1'b1, 1'b0);
        run_edges(3);
        push("H2", 4'b1011, G2, 1'b1, 1'b0);
        push("H3", 4'b0111, G1, 1'b1, 1'b0);
        run_edges(1);
        run_edges(REF);
        blink_mask = 4'b0001;
        blank_mask = 4'b0100;
        for (int f = 0; f < 8; f++) begin
            ph = ((ecyc + REF - 1) >> 5) & 1;
            if (ph != 0) push("I0_blink", 4'b1111, GDARK, 1'b1, 1'b1, 1'b0);
            else push("I0_lit", 4'b1110, G4, 1'b1, 1'b1);
            push("I1", 4'b1101, G3, 1'b1, 1'b0);
            push("I2_blank", 4'b1111, GDARK, 1'b1, 1'b0, 1'b0);
            push("I3", 4'b0111, G1, 1'b1, 1'b0);
            repeat (4) run_edges(REF);
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
